vpu_lane_array: RTL and testbench

//  Multi-lane, pipelined successor to the single-element VPU ALU. Streams a vector of
//  VEC beats (LANES fp32 elements per beat) through one latched opcode, with valid/ready

---
 rtl/vpu_lane_array.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_vpu_lane_array.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_lane_array.sv
// Multi-lane pipelined fp32 vector ALU with a vector-length sequencer.
// Ports: clk/rst, start+opcode+vec_len, in_* beat, out_* beat, busy/done.
module vpu_lane_array #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int OP_W    = 10,
  parameter int LATENCY = 2,
  parameter int LEN_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [OP_W-1:0]         opcode,
  input  logic [LEN_W-1:0]        vec_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] operand0,
  input  logic [LANES*DATA_W-1:0] operand1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] result_out,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_RELU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DREL = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MAX  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MIN  = OP_W'(6);

  // fp32 add, round-to-nearest-even, subnormals flushed to zero.
  function automatic logic [31:0] fp_add(
    input logic [31:0] a_in,
    input logic [31:0] b_in
  );
    logic [31:0] a, b, x, y;
    logic [26:0] mx, my, mask;
    logic [27:0] s;
    logic [24:0] r;
    logic [7:0]  d;
    logic        sx, rnd;
    int          e;
    a = (a_in[30:23] == 8'd0) ? {a_in[31], 31'd0} : a_in;
    b = (b_in[30:23] == 8'd0) ? {b_in[31], 31'd0} : b_in;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sx = x[31];
    if (x[30:23] == 8'hff) return x;
    if (x[30:0] == 31'd0) return {a[31] & b[31], 31'd0};
    if (y[30:0] == 31'd0) return x;
    mx = {1'b1, x[22:0], 3'd0};
    my = {1'b1, y[22:0], 3'd0};
    d  = x[30:23] - y[30:23];
    // Bits shifted out of the smaller operand fold into sticky.
    if (d > 8'd26) begin
      my = 27'd1;
    end else begin
      mask = (27'd1 << d) - 27'd1;
      my   = (my >> d) | {26'd0, |(my & mask)};
    end
    e = int'({24'd0, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, mx - my};
      if (s == 28'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    r   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (r[24]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sx, 8'hff, 23'd0};
    if (e <= 0) return {sx, 31'd0};
    return {sx, e[7:0], r[22:0]};
  endfunction

  // fp32 multiply, round-to-nearest-even, subnormals flushed to zero.
  function automatic logic [31:0] fp_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic        sg, g, st;
    logic [47:0] p;
    logic [22:0] m;
    logic [24:0] r;
    int          e;
    sg = a[31] ^ b[31];
    if (a[30:23] == 8'hff || b[30:23] == 8'hff)
      return {sg, 8'hff, 23'd0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {sg, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'({24'd0, a[30:23]}) + int'({24'd0, b[30:23]}) - 127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {2'b01, m} + {24'd0, g & (st | m[0])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sg, 8'hff, 23'd0};
    if (e <= 0) return {sg, 31'd0};
    return {sg, e[7:0], r[22:0]};
  endfunction

  // Ordered-key compare; signed zeros compare equal.
  function automatic logic fp_gt(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] ka, kb;
    if ((a[30:0] | b[30:0]) == 31'd0) return 1'b0;
    ka = a[31] ? ~a : {1'b1, a[30:0]};
    kb = b[31] ? ~b : {1'b1, b[30:0]};
    return ka > kb;
  endfunction

  function automatic logic [31:0] lane_op(
    input logic [OP_W-1:0] op,
    input logic [31:0]     a,
    input logic [31:0]     b
  );
    logic [31:0] r;
    case (op)
      OP_ADD:  r = fp_add(a, b);
      OP_SUB:  r = fp_add(a, {~b[31], b[30:0]});
      OP_RELU: r = a[31] ? 32'd0 : a;
      OP_MUL:  r = fp_mul(a, b);
      OP_DREL: begin
        if (a[31] || a[30:0] == 31'd0) r = 32'd0;
        else r = 32'h3f800000;
      end
      OP_MAX:  r = fp_gt(b, a) ? b : a;
      OP_MIN:  r = fp_gt(a, b) ? b : a;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        acc_q, acc_d;
  logic [LEN_W-1:0]        emit_q, emit_d;
  logic                    done_q, done_d;
  logic [LANES*DATA_W-1:0] pdata_q [LATENCY];
  logic [LANES*DATA_W-1:0] pdata_d [LATENCY];
  logic [LATENCY-1:0]      pvld_q, pvld_d;
  logic [LATENCY-1:0]      plast_q, plast_d;
  logic [LANES*DATA_W-1:0] lane_res;
  logic                    advance, in_fire, out_fire;

  assign out_valid  = pvld_q[LATENCY-1];
  assign result_out = pdata_q[LATENCY-1];
  assign out_last   = plast_q[LATENCY-1];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // One global stall: every stage holds while the output is blocked.
  assign advance  = !out_valid || out_ready;
  assign in_ready = (state_q == RUN) && (acc_q < len_q) && advance;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    lane_res = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res[i*DATA_W +: DATA_W] = lane_op(
        op_q,
        operand0[i*DATA_W +: DATA_W],
        operand1[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    pdata_d = pdata_q;
    pvld_d  = pvld_q;
    plast_d = plast_q;
    if (advance) begin
      pdata_d[0] = in_fire ? lane_res : '0;
      pvld_d[0]  = in_fire;
      // Beats stay in order, so the accept index is the emit index.
      plast_d[0] = in_fire && (acc_q == len_q - LEN_W'(1));
      for (int s = 1; s < LATENCY; s++) begin
        pdata_d[s] = pdata_q[s-1];
        pvld_d[s]  = pvld_q[s-1];
        plast_d[s] = plast_q[s-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    acc_d   = in_fire ? acc_q + LEN_W'(1) : acc_q;
    emit_d  = out_fire ? emit_q + LEN_W'(1) : emit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = opcode;
          len_d  = vec_len;
          acc_d  = '0;
          emit_d = '0;
          if (vec_len == '0) done_d = 1'b1;
          else state_d = RUN;
        end
      end
      RUN: begin
        if (acc_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (emit_d == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      emit_q  <= '0;
      done_q  <= 1'b0;
      pvld_q  <= '0;
      plast_q <= '0;
      for (int s = 0; s < LATENCY; s++) pdata_q[s] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      emit_q  <= emit_d;
      done_q  <= done_d;
      pvld_q  <= pvld_d;
      plast_q <= plast_d;
      pdata_q <= pdata_d;
    end
  end

endmodule

// File: tb/tb_vpu_lane_array.sv
// Scoreboard bench for vpu_lane_array: directed vectors, queued
// expectations, independent output monitor.
module tb_vpu_lane_array;

  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [9:0]    opcode = '0;
  logic [15:0]   vec_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  operand0 = '0;
  logic [127:0]  operand1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [127:0]  result_out;
  logic          out_last;
  logic          busy;
  logic          done;

  vpu_lane_array dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .vec_len(vec_len), .in_valid(in_valid), .in_ready(in_ready),
    .operand0(operand0), .operand1(operand1),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_out(result_out), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         last;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int out_cnt = 0;
  int ov_cnt = 0;
  int ir_cnt = 0;
  int last_out_cyc = 0;
  int acc_cyc = 0;
  bit bp_mode = 1'b0;

  logic         pstall = 1'b0;
  logic [127:0] pdat = '0;
  logic         plst = 1'b0;

  // Hand-computed fp32 vectors: {operand0, operand1, expected}.
  localparam logic [31:0] TA [23] = '{
    32'h3f800000, 32'h40400000, 32'h40800000, 32'h3fc00000,
    32'h41200000, 32'h3f800000, 32'h40000000, 32'hc1000000,
    32'hbf800000, 32'hbf800000, 32'h40400000, 32'hbf800000,
    32'h00000000, 32'h40000000, 32'hbf800000, 32'h80000000,
    32'hc1000000, 32'hbf800000, 32'h80000000, 32'h41200000,
    32'h3fc00000, 32'h40400000, 32'h40400000};
  localparam logic [31:0] TB [23] = '{
    32'h40000000, 32'h3f800000, 32'h40800000, 32'h3fc00000,
    32'hc0a00000, 32'hbf800000, 32'h3f000000, 32'h40000000,
    32'h40000000, 32'h40000000, 32'h3f800000, 32'h40000000,
    32'h40000000, 32'hbf800000, 32'h40000000, 32'h00000000,
    32'hc0a00000, 32'h40000000, 32'h00000000, 32'h40a00000,
    32'h3fc00000, 32'hc0000000, 32'h3f800000};
  localparam logic [31:0] TE [23] = '{
    32'h40400000, 32'h40800000, 32'h41000000, 32'h40400000,
    32'h40a00000, 32'h00000000, 32'h40200000, 32'hc0c00000,
    32'hc0400000, 32'h00000000, 32'h40400000, 32'h00000000,
    32'h00000000, 32'h3f800000, 32'h40000000, 32'h80000000,
    32'hc0a00000, 32'hbf800000, 32'h80000000, 32'h40a00000,
    32'h40100000, 32'hc0c00000, 32'h00000000};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? cyc[0] : 1'b1;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Output monitor: pops and compares on every output handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pstall = 1'b0;
    end else begin
      if (in_ready) ir_cnt++;
      if (out_valid) ov_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pstall) begin
        checks++;
        if (!out_valid || result_out !== pdat || out_last !== plst) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   out_valid, result_out, out_last, pdat, plst);
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        last_out_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h required none", result_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (result_out !== e.d || out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got %h last=%b required %h last=%b",
                     result_out, out_last, e.d, e.last);
          end
        end
      end
      pstall = out_valid && !out_ready;
      pdat   = result_out;
      plst   = out_last;
    end
  end

  function automatic logic [127:0] pack(input int base, input int cnt,
                                        input int k, input int w);
    logic [127:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < LN; i++) begin
      idx = base + ((k + i) % cnt);
      case (w)
        0: v[i*32 +: 32] = TA[idx];
        1: v[i*32 +: 32] = TB[idx];
        default: v[i*32 +: 32] = TE[idx];
      endcase
    end
    return v;
  endfunction

  task automatic do_start(input logic [9:0] op, input int len);
    @(posedge clk);
    #1;
    start   = 1'b1;
    opcode  = op;
    vec_len = 16'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input logic [9:0] op, input int base,
                         input int cnt, input int len, input bit bp,
                         input int ab, input bit poke);
    int k, t, d0, o0;
    bit hs;
    exp_t e;
    bp_mode = bp;
    for (int j = 0; j < len; j++) begin
      e.d    = pack(base, cnt, j, 2);
      e.last = (j == len - 1);
      sb.push_back(e);
    end
    d0 = done_cnt;
    o0 = out_cnt;
    do_start(op, len);
    k = 0;
    t = 0;
    while (k < len && t < 1000 && !(ab > 0 && out_cnt >= o0 + ab)) begin
      in_valid = 1'b1;
      operand0 = pack(base, cnt, k, 0);
      operand1 = pack(base, cnt, k, 1);
      start    = poke && (t == 1);
      if (start) begin
        opcode  = 10'd3;
        vec_len = 16'd1;
      end
      @(negedge clk);
      hs = in_ready;
      if (hs && k == 0) acc_cyc = cyc;
      if (poke && t == 1) chk("busy_when_poked", busy, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (hs) k++;
      t++;
    end
    if (ab > 0) return;
    chk("accept_count", k, len);
    @(negedge clk);
    chk("in_ready_drop", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("sb_empty", sb.size(), 0);
    chk("idle_busy", busy, 0);
    bp_mode = 1'b0;
  endtask

  initial begin
    int d0, ir0, ov0, st;
    #12;
    chk("reset_ctrl", {out_valid, out_last, busy, done, in_ready}, 0);
    chk("reset_result", result_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_vec(10'd0, 0, 1, 1, 0, 0, 0);
    chk("t1_latency", last_out_cyc - acc_cyc, 2);
    chk("t1_done_cycle", done_cyc - last_out_cyc, 1);

    run_vec(10'd1, 8, 1, 1, 0, 0, 0);
    run_vec(10'd2, 9, 2, 2, 0, 0, 0);
    run_vec(10'd4, 11, 3, 3, 0, 0, 0);
    run_vec(10'd5, 14, 3, 3, 0, 0, 0);
    run_vec(10'd6, 17, 3, 3, 0, 0, 0);
    run_vec(10'd3, 20, 2, 2, 0, 0, 0);

    run_vec(10'd0, 0, 8, 8, 0, 0, 0);
    chk("t3_stream_cycles", last_out_cyc - acc_cyc, 9);

    run_vec(10'd0, 0, 8, 8, 1, 0, 0);
    run_vec(10'd0, 3, 5, 5, 1, 0, 0);

    d0  = done_cnt;
    ir0 = ir_cnt;
    ov0 = ov_cnt;
    do_start(10'd0, 0);
    st = cyc - 1;
    repeat (4) @(posedge clk);
    #1;
    chk("zero_len_done", done_cnt - d0, 1);
    chk("zero_len_done_cyc", done_cyc - st, 1);
    chk("zero_len_no_ready", ir_cnt - ir0, 0);
    chk("zero_len_no_valid", ov_cnt - ov0, 0);
    run_vec(10'd0, 0, 4, 4, 0, 0, 1);

    d0 = done_cnt;
    run_vec(10'd0, 0, 8, 8, 0, 3, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {out_valid, out_last, busy, in_ready}, 0);
    chk("midrst_result", result_out, 0);
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_no_done", done_cnt - d0, 0);
    run_vec(10'd7, 22, 1, 2, 0, 0, 0);
    run_vec(10'd0, 0, 8, 3, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
